// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level arbiter sharing one UART TX FIFO between two
// requesters. One requester holds the grant for a whole packet, bytes are
// pushed at most every other cycle and only while the FIFO has room, grants
// alternate between packets, and a stalled grant is reclaimed after TIMEOUT
// idle cycles.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; pick a requester (rr_q breaks ties) and move to SEND
// SEND  | granted requester streams bytes until last=1 or idle timeout
module uart_tx_arbiter #(
    parameter int FIFO_DEPTH = 16,
    parameter int COUNT_W    = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               tx_reset,
    input  logic               req0_valid,
    input  logic [7:0]         req0_data,
    input  logic               req0_last,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [7:0]         req1_data,
    input  logic               req1_last,
    output logic               req1_ready,
    output logic               tf_push,
    output logic [7:0]         dat_o,
    input  logic [COUNT_W-1:0] tf_count,
    input  logic               tf_overrun,
    output logic [1:0]         gnt,
    output logic               timeout_err,
    output logic               ovr_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;

    localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(FIFO_DEPTH);
    // The idle counter fires one cycle early so the registered timeout pulse
    // lands exactly TIMEOUT cycles after valid first drops.
    localparam logic [7:0]         IDLE_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       rr_q, rr_d;
    logic [7:0] idle_q, idle_d;
    logic       timeout_q, timeout_d;
    logic       tf_push_q;
    logic [7:0] dat_q;
    logic       ovr_q;

    logic       space_ok;
    logic       xfer0, xfer1, xfer;
    logic       sel_valid, sel_last;
    logic [7:0] sel_data;

    // Space check uses the registered push so tf_count has caught up with
    // the previous byte before the next one is accepted.
    assign space_ok   = !tf_push_q && (tf_count < DEPTH_C);
    assign req0_ready = (state_q == ST_SEND) && gnt_q[0] && space_ok;
    assign req1_ready = (state_q == ST_SEND) && gnt_q[1] && space_ok;

    assign xfer0 = req0_valid && req0_ready;
    assign xfer1 = req1_valid && req1_ready;
    assign xfer  = xfer0 || xfer1;

    assign sel_valid = gnt_q[1] ? req1_valid : req0_valid;
    assign sel_last  = gnt_q[1] ? req1_last  : req0_last;
    assign sel_data  = gnt_q[1] ? req1_data  : req0_data;

    // Next-state: grant selection, packet end, idle timeout.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        idle_d    = idle_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_d  = 2'b00;
                idle_d = 8'd0;
                if (req0_valid && req1_valid) begin
                    gnt_d   = rr_q ? 2'b10 : 2'b01;
                    state_d = ST_SEND;
                end else if (req0_valid) begin
                    gnt_d   = 2'b01;
                    state_d = ST_SEND;
                end else if (req1_valid) begin
                    gnt_d   = 2'b10;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    idle_d = 8'd0;
                    if (sel_last) begin
                        gnt_d   = 2'b00;
                        rr_d    = gnt_q[0];
                        state_d = ST_IDLE;
                    end
                end else if (!sel_valid) begin
                    if (idle_q == IDLE_LAST) begin
                        timeout_d = 1'b1;
                        gnt_d     = 2'b00;
                        rr_d      = gnt_q[0];
                        idle_d    = 8'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        idle_d = idle_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
                idle_d  = 8'd0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (tx_reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 2'b00;
            rr_q      <= 1'b0;
            idle_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    // Transfer path: push pulse and data byte one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (tx_reset) begin
            tf_push_q <= 1'b0;
            dat_q     <= 8'h00;
        end else begin
            tf_push_q <= xfer;
            if (xfer) begin
                dat_q <= sel_data;
            end
        end
    end

    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (tx_reset) begin
            ovr_q <= 1'b0;
        end else if (tf_overrun) begin
            ovr_q <= 1'b1;
        end
    end

    assign tf_push     = tf_push_q;
    assign dat_o       = dat_q;
    assign gnt         = gnt_q;
    assign timeout_err = timeout_q;
    assign ovr_err     = ovr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a cycle table for contention and
// FIFO-full throttling, plus hand-written fairness, timeout, reset and
// overrun sequences.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       tx_reset;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic       tf_push;
    logic [7:0] dat_o;
    logic [4:0] tf_count;
    logic       tf_overrun;
    logic [1:0] gnt;
    logic       timeout_err;
    logic       ovr_err;

    int nchk = 0;
    int nerr = 0;

    uart_tx_arbiter #(.FIFO_DEPTH(16), .COUNT_W(5), .TIMEOUT(8)) dut (
        .clk        (clk),
        .tx_reset   (tx_reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .tf_push    (tf_push),
        .dat_o      (dat_o),
        .tf_count   (tf_count),
        .tf_overrun (tf_overrun),
        .gnt        (gnt),
        .timeout_err(timeout_err),
        .ovr_err    (ovr_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic [4:0] cnt;
        logic [1:0] e_gnt;
        logic       e_r0;
        logic       e_r1;
        logic       e_push;
        logic [7:0] e_dat;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
        tf_count   = 5'd0; tf_overrun = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        tx_reset = 1'b1;
        tick();
        tick();
        tx_reset = 1'b0;
    endtask

    function automatic logic [13:0] obs();
        return {gnt, req0_ready, req1_ready, tf_push, dat_o, timeout_err};
    endfunction

    initial begin
        logic       gorder [4];
        logic [7:0] porder [4];
        logic       g_exp  [4];
        logic [7:0] p_exp  [4];
        int n0, n1, ng, np, k, tk, nx;
        logic [1:0] prev;
        logic found;

        tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b1, 8'h61, 1'b1, 5'd0,  2'b00, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 8'h41, 1'b0, 1'b1, 8'h61, 1'b1, 5'd0,  2'b01, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 8'h42, 1'b1, 1'b1, 8'h61, 1'b1, 5'd0,  2'b01, 1'b0, 1'b0, 1'b1, 8'h41};
        tbl[3]  = '{1'b1, 8'h42, 1'b1, 1'b1, 8'h61, 1'b1, 5'd0,  2'b01, 1'b1, 1'b0, 1'b0, 8'h41};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h61, 1'b1, 5'd0,  2'b00, 1'b0, 1'b0, 1'b1, 8'h42};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h61, 1'b1, 5'd0,  2'b10, 1'b0, 1'b1, 1'b0, 8'h42};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0,  2'b00, 1'b0, 1'b0, 1'b1, 8'h61};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0,  2'b00, 1'b0, 1'b0, 1'b0, 8'h61};
        tbl[8]  = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 5'd16, 2'b00, 1'b0, 1'b0, 1'b0, 8'h61};
        tbl[9]  = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 5'd16, 2'b01, 1'b0, 1'b0, 1'b0, 8'h61};
        tbl[10] = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 5'd16, 2'b01, 1'b0, 1'b0, 1'b0, 8'h61};
        tbl[11] = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 5'd15, 2'b01, 1'b1, 1'b0, 1'b0, 8'h61};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 5'd16, 2'b00, 1'b0, 1'b0, 1'b1, 8'h55};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 5'd16, 2'b00, 1'b0, 1'b0, 1'b0, 8'h55};

        g_exp = '{1'b0, 1'b1, 1'b0, 1'b0};
        p_exp = '{8'h10, 8'h70, 8'h11, 8'h12};

        // Reset state while reset is held.
        idle_inputs();
        tx_reset = 1'b1;
        tick();
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("reset_outputs", 16'({obs(), ovr_err}), 16'h0000);
        tick();

        // Contention then FIFO-full throttling, cycle by cycle.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            req0_valid = tbl[i].v0; req0_data = tbl[i].d0; req0_last = tbl[i].l0;
            req1_valid = tbl[i].v1; req1_data = tbl[i].d1; req1_last = tbl[i].l1;
            tf_count   = tbl[i].cnt;
            #1;
            chk($sformatf("vec[%0d]", i), 16'(obs()),
                16'({tbl[i].e_gnt, tbl[i].e_r0, tbl[i].e_r1, tbl[i].e_push, tbl[i].e_dat, 1'b0}));
            tick();
        end

        // Fairness: req0 offers three 1-byte packets, req1 one.
        do_reset();
        n0 = 0; n1 = 0; ng = 0; np = 0; prev = 2'b00;
        for (int c = 0; c < 80 && (ng < 4 || np < 4); c++) begin
            req0_valid = (n0 < 3); req0_data = 8'h10 + 8'(n0); req0_last = 1'b1;
            req1_valid = (n1 < 1); req1_data = 8'h70;          req1_last = 1'b1;
            #1;
            if (gnt != 2'b00 && prev == 2'b00 && ng < 4) begin
                gorder[ng] = gnt[1];
                ng++;
            end
            prev = gnt;
            if (tf_push && np < 4) begin
                porder[np] = dat_o;
                np++;
            end
            if (req0_valid && req0_ready) n0++;
            if (req1_valid && req1_ready) n1++;
            tick();
        end
        chk("fair_grants_seen", 16'(ng), 16'd4);
        chk("fair_pushes_seen", 16'(np), 16'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) chk($sformatf("fair_gnt[%0d]", i), 16'(gorder[i]), 16'(g_exp[i]));
            if (i < np) chk($sformatf("fair_push[%0d]", i), 16'(porder[i]), 16'(p_exp[i]));
        end

        // Timeout: req1 sends one byte without last, then stalls.
        do_reset();
        req1_valid = 1'b1; req1_data = 8'h33; req1_last = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (req1_ready) found = 1'b1;
            tick();
        end
        chk("to_first_xfer", 16'(found), 16'd1);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h44; req0_last = 1'b1;
        #1;
        chk("to_push_byte", 16'({tf_push, dat_o}), 16'h0133);
        found = 1'b0; tk = -1; k = 0;
        while (k < 30 && !found) begin
            if (timeout_err) begin
                found = 1'b1;
                tk = k;
                chk("to_gnt_at_pulse", 16'(gnt), 16'h0000);
            end else begin
                tick();
                #1;
                k++;
            end
        end
        chk("to_latency", 16'(tk), 16'd8);
        tick();
        #1;
        chk("to_pulse_then_req0", 16'({timeout_err, gnt}), 16'h0001);

        // Reset mid-packet with requester 1 holding the round-robin pointer.
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hA0; req0_last = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (req0_ready) found = 1'b1;
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 8'hB0; req1_last = 1'b0;
        nx = 0;
        for (int c = 0; c < 20 && nx < 2; c++) begin
            #1;
            if (req1_ready) nx++;
            tick();
            req1_data = 8'hB0 + 8'(nx);
        end
        chk("rst_two_bytes", 16'(nx), 16'd2);
        tx_reset = 1'b1;
        req0_valid = 1'b1; req0_data = 8'hC0; req0_last = 1'b1;
        tick();
        tx_reset = 1'b0;
        #1;
        chk("rst_clears_path", 16'({gnt, tf_push, dat_o, req0_ready, req1_ready}), 16'h0000);
        tick();
        #1;
        chk("rst_then_req0", 16'(gnt), 16'h0001);

        // Sticky overrun flag.
        do_reset();
        #1;
        chk("ovr_initial", 16'(ovr_err), 16'd0);
        tick();
        tf_overrun = 1'b1;
        tick();
        tf_overrun = 1'b0;
        #1;
        chk("ovr_set", 16'(ovr_err), 16'd1);
        for (int c = 0; c < 5; c++) tick();
        #1;
        chk("ovr_sticky", 16'(ovr_err), 16'd1);
        tx_reset = 1'b1;
        tick();
        tx_reset = 1'b0;
        #1;
        chk("ovr_cleared", 16'(ovr_err), 16'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
